// File: rtl/cdc_pkg.sv
// Shared types and constants for the bundled-data toggle CDC blocks.
package cdc_pkg;

  typedef enum logic {RX_IDLE = 1'b0, RX_VALID = 1'b1} rx_state_t;

  localparam int SYNC_STAGES_MIN = 2;

  // Clamp a requested synchronizer depth to the minimum safe depth.
  function automatic int sync_depth(input int n);
    return (n < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : n;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// 1-bit async-reset synchronizer chain; q is the last stage.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/cdc_handshake_rx.sv
// Destination side of a toggle request/ack CDC handshake with a valid/ready output.
module cdc_handshake_rx
  import cdc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             req_tgl_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ack_tgl_a,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int STAGES = sync_depth(SYNC_STAGES);

  rx_state_t state, state_nxt;
  logic      req_s, req_seen, evt;
  logic      capture, accept;

  sync_ff_chain #(.STAGES(STAGES)) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (req_tgl_a),
    .q     (req_s)
  );

  assign evt     = req_s ^ req_seen;
  assign capture = ena && (state == RX_IDLE) && evt;
  assign accept  = ena && (state == RX_VALID) && out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (capture) state_nxt = RX_VALID;
      RX_VALID: if (accept)  state_nxt = RX_IDLE;
      default:  state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RX_VALID);
  end

  // data_a is guaranteed stable by the source once the toggle is visible here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      req_seen  <= 1'b0;
      ack_tgl_a <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      if (capture) begin
        out_data  <= data_a;
        out_valid <= 1'b1;
        req_seen  <= req_s;
      end
      if (accept) begin
        out_valid <= 1'b0;
        ack_tgl_a <= ~ack_tgl_a;
        xfer_cnt  <= xfer_cnt + 1'b1;
      end
    end
  end

  // req_seen is left stale on overrun so the pending event is taken on return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             overrun <= 1'b0;
    else if (ena) begin
      if ((state == RX_VALID) && evt)       overrun <= 1'b1;
      else if (clr_overrun)                 overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Directed plus randomized bench for cdc_handshake_rx against a transfer-level model.
module tb_cdc_handshake_rx;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic             req_tgl_a;
  logic [WIDTH-1:0] data_a;
  logic             ack_tgl_a;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;
  logic             clr_overrun;
  logic [CNT_W-1:0] xfer_cnt;

  int   checks = 0;
  int   errors = 0;
  logic exp_ack = 1'b0;
  int   exp_cnt = 0;

  cdc_handshake_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .req_tgl_a   (req_tgl_a),
    .data_a      (data_a),
    .ack_tgl_a   (ack_tgl_a),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .xfer_cnt    (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    data_a    = d;
    req_tgl_a = ~req_tgl_a;
  endtask

  // One full source transaction with bp cycles of backpressure after capture.
  task automatic do_xfer(input logic [WIDTH-1:0] d, input int bp);
    send(d);
    out_ready = 1'b0;
    repeat (SYNC) step();
    check("pre_valid", out_valid, 0);
    step();
    check("valid", out_valid, 1);
    check("data", out_data, d);
    check("busy", busy, 1);
    for (int i = 0; i < bp; i++) begin
      step();
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, d);
      check("hold_ack", ack_tgl_a, exp_ack);
      check("hold_busy", busy, 1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_ack   = ~exp_ack;
    exp_cnt++;
    check("acc_valid", out_valid, 0);
    check("acc_ack", ack_tgl_a, exp_ack);
    check("acc_cnt", xfer_cnt, exp_cnt % (1 << CNT_W));
    check("acc_keep", out_data, d);
    step();
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; req_tgl_a = 1'b0; data_a = '0;
    out_ready = 1'b0; clr_overrun = 1'b0;
    step(); step();
    check("rst_valid", out_valid, 0);
    check("rst_ack", ack_tgl_a, 0);
    check("rst_cnt", xfer_cnt, 0);
    check("rst_data", out_data, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // single transfer, immediate accept
    do_xfer(8'hA5, 0);
    // backpressure for 10 cycles
    do_xfer(8'h3C, 10);

    // overrun: second request lands while 8'h22 is pending
    send(8'h22);
    repeat (SYNC + 1) step();
    check("ovr_first", out_data, 8'h22);
    send(8'h11);
    repeat (SYNC) step();
    check("ovr_not_yet", overrun, 0);
    step();
    check("ovr_set", overrun, 1);
    check("ovr_stable", out_data, 8'h22);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    exp_ack = ~exp_ack; exp_cnt++;
    check("ovr_acc1", ack_tgl_a, exp_ack);
    check("ovr_gap", out_valid, 0);
    step();
    check("ovr_cap2", out_valid, 1);
    check("ovr_data2", out_data, 8'h11);
    check("ovr_sticky", overrun, 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    exp_ack = ~exp_ack; exp_cnt++;
    check("ovr_acc2", ack_tgl_a, exp_ack);
    check("ovr_cnt", xfer_cnt, exp_cnt % (1 << CNT_W));
    step();

    // clr alone clears
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    check("clr_alone", overrun, 0);

    // clr held across a new set: set wins
    send(8'h44);
    repeat (SYNC + 1) step();
    clr_overrun = 1'b1;
    send(8'h55);
    repeat (SYNC) step();
    check("clr_pre", overrun, 0);
    step();
    clr_overrun = 1'b0;
    check("clr_vs_set", overrun, 1);
    out_ready = 1'b1; step();
    exp_ack = ~exp_ack; exp_cnt++;
    step();
    check("clr_cap55", out_data, 8'h55);
    step(); out_ready = 1'b0;
    exp_ack = ~exp_ack; exp_cnt++;
    check("clr_ack", ack_tgl_a, exp_ack);
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    check("clr_again", overrun, 0);

    // ena gating: no capture while disabled, capture on the first enabled edge
    ena = 1'b0;
    send(8'h77);
    repeat (SYNC + 3) step();
    check("ena_nocap", out_valid, 0);
    check("ena_data", out_data, 8'h55);
    check("ena_cnt", xfer_cnt, exp_cnt % (1 << CNT_W));
    ena = 1'b1;
    step();
    check("ena_cap", out_valid, 1);
    check("ena_cap_data", out_data, 8'h77);
    ena = 1'b0; out_ready = 1'b1;
    step(); step();
    check("ena_ready_ign", out_valid, 1);
    check("ena_ack_hold", ack_tgl_a, exp_ack);
    ena = 1'b1;
    step(); out_ready = 1'b0;
    exp_ack = ~exp_ack; exp_cnt++;
    check("ena_acc", ack_tgl_a, exp_ack);
    step();

    // randomized traffic
    for (int n = 0; n < 20; n++)
      do_xfer(WIDTH'($urandom), int'($urandom_range(0, 4)));

    // run the counter to its wrap point
    while ((exp_cnt % (1 << CNT_W)) != 0)
      do_xfer(WIDTH'($urandom), 0);
    check("cnt_wrap", xfer_cnt, 0);

    // reset mid-transfer drops the word and leaves ack at its reset value
    send(8'h99);
    repeat (SYNC + 1) step();
    check("mid_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mr_valid", out_valid, 0);
    check("mr_ack", ack_tgl_a, 0);
    check("mr_cnt", xfer_cnt, 0);
    check("mr_data", out_data, 0);
    check("mr_busy", busy, 0);
    check("mr_ovr", overrun, 0);
    req_tgl_a = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (SYNC + 2) step();
    check("post_valid", out_valid, 0);
    check("post_ack", ack_tgl_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
